// File: rtl/soc_data_bus.sv
// Data-side bus fabric: picks a slave from the top address bits, registers the
// access, runs a request/ready handshake with a timeout and stalls the core
// until the access completes. Unmapped or timed-out accesses report bus_err.
`timescale 1ns/1ps
module soc_data_bus #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int IDX_W      = 2,
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 16,
   parameter logic [DATA_WIDTH-1:0] ERR_RDATA = '0
) (
   input  logic                           clk,
   input  logic                           _rst,
   input  logic                           data_w_en,
   input  logic                           data_r_en,
   input  logic [DATA_WIDTH/8-1:0]        data_sel,
   input  logic [ADDR_WIDTH-1:0]          data_addr,
   input  logic [DATA_WIDTH-1:0]          data_out,
   output logic [DATA_WIDTH-1:0]          data_in,
   output logic                           stall,
   output logic                           bus_err,
   output logic [NUM_SLAVES-1:0]          s_req,
   output logic                           s_we,
   output logic [DATA_WIDTH/8-1:0]        s_sel,
   output logic [ADDR_WIDTH-1:0]          s_addr,
   output logic [DATA_WIDTH-1:0]          s_wdata,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
   input  logic [NUM_SLAVES-1:0]          s_ready
);

   localparam int SEL_W = DATA_WIDTH/8;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                  state_q, state_d;
   logic [NUM_SLAVES-1:0]   s_req_q, s_req_d;
   logic                    we_q, we_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;

   logic                    req;
   logic                    mapped;
   logic [IDX_W-1:0]        idx;
   logic [NUM_SLAVES-1:0]   req_onehot;
   logic                    sel_ready;
   logic [DATA_WIDTH-1:0]   sel_rdata;

   assign req    = data_w_en | data_r_en;
   assign idx    = data_addr[ADDR_WIDTH-1 -: IDX_W];
   assign mapped = ({1'b0, idx} < (IDX_W+1)'(NUM_SLAVES));

   // Decode the incoming index to a one-hot request and mux the latched slave's ready/data
   always_comb begin
      req_onehot = '0;
      sel_ready  = 1'b0;
      sel_rdata  = '0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         req_onehot[k] = (idx == IDX_W'(k));
         if (idx_q == IDX_W'(k)) begin
            sel_ready = s_ready[k];
            sel_rdata = s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state logic: launch in IDLE, wait for ready or timeout in ACCESS, one-cycle DONE
   always_comb begin
      state_d = state_q;
      s_req_d = s_req_q;
      we_d    = we_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (mapped) begin
                  // a simultaneous read enable is ignored: the access is a write
                  we_d    = data_w_en;
                  sel_d   = data_sel;
                  addr_d  = data_addr;
                  wdata_d = data_out;
                  idx_d   = idx;
                  s_req_d = req_onehot;
                  cnt_d   = '0;
                  state_d = ACCESS;
               end else begin
                  err_d   = 1'b1;
                  rdata_d = ERR_RDATA;
                  state_d = DONE;
               end
            end
         end
         ACCESS: begin
            if (sel_ready) begin
               s_req_d = '0;
               err_d   = 1'b0;
               if (!we_q) rdata_d = sel_rdata;
               state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               s_req_d = '0;
               err_d   = 1'b1;
               rdata_d = ERR_RDATA;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            // the request still held here is the one just completed; never relaunch it
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            s_req_d = '0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and access registers; reset also aborts an in-flight access without completion
   always_ff @(posedge clk) begin
      if (!_rst) begin
         state_q <= IDLE;
         s_req_q <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_req_q <= s_req_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign stall   = ((state_q == IDLE) & req) | (state_q == ACCESS);
   assign bus_err = err_q;
   assign data_in = rdata_q;
   assign s_req   = s_req_q;
   assign s_we    = we_q;
   assign s_sel   = sel_q;
   assign s_addr  = addr_q;
   assign s_wdata = wdata_q;

endmodule

// File: tb/tb_soc_data_bus.sv
// Bench for soc_data_bus with three populated slaves out of four index slots.
// A slave responder raises ready a programmable number of cycles into each
// access; expected results are queued at launch and compared at DONE.
`timescale 1ns/1ps
module tb_soc_data_bus;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int NS  = 3;
   localparam int TO  = 16;

   logic            clk;
   logic            rst_n;
   logic            data_w_en, data_r_en;
   logic [3:0]      data_sel;
   logic [AW-1:0]   data_addr;
   logic [DW-1:0]   data_out;
   logic [DW-1:0]   data_in;
   logic            stall, bus_err;
   logic [NS-1:0]   s_req;
   logic            s_we;
   logic [3:0]      s_sel;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_wdata;
   logic [NS*DW-1:0] s_rdata;
   logic [NS-1:0]   s_ready;

   logic [DW-1:0]   slv_rd [NS];
   int              ready_dly;
   logic [NS-1:0]   spur;
   int              acc_cyc;

   int              n_chk;
   int              n_fail;
   logic [DW-1:0]   last_din;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            stalls;
      int            req_cycles;
   } exp_t;
   exp_t sb_q[$];

   soc_data_bus #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IDX_W(2), .NUM_SLAVES(NS),
      .TIMEOUT(TO), .ERR_RDATA(32'h0)
   ) dut (
      .clk(clk), ._rst(rst_n),
      .data_w_en(data_w_en), .data_r_en(data_r_en), .data_sel(data_sel),
      .data_addr(data_addr), .data_out(data_out), .data_in(data_in),
      .stall(stall), .bus_err(bus_err),
      .s_req(s_req), .s_we(s_we), .s_sel(s_sel), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign s_rdata = {slv_rd[2], slv_rd[1], slv_rd[0]};

   // Slave responder: ready after ready_dly ACCESS cycles (negative = never), plus spurious bits
   always @(negedge clk) begin
      if (s_req != '0) begin
         s_ready = ((ready_dly >= 0) && (acc_cyc >= ready_dly)) ? s_req : '0;
         s_ready = s_ready | spur;
         acc_cyc = acc_cyc + 1;
      end else begin
         acc_cyc = 0;
         s_ready = spur;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one access at a negedge, follow it to DONE and compare with the queued expectation
   task automatic do_acc(input string name, input logic we, input logic re,
                         input logic [AW-1:0] addr, input logic [3:0] sel,
                         input logic [DW-1:0] wd, input int dly);
      exp_t          e;
      logic [1:0]    idx;
      logic [NS-1:0] exp_req;
      logic          is_wr;
      int            stalls, reqc, bad, guard;
      idx     = addr[AW-1 -: 2];
      is_wr   = we;
      exp_req = '0;
      if (idx < NS) begin
         exp_req = NS'(1) << idx;
         if (dly < 0 || dly >= TO) begin
            e.err = 1'b1; e.rdata = 32'h0; e.stalls = 1 + TO; e.req_cycles = TO;
         end else begin
            e.err = 1'b0; e.rdata = is_wr ? last_din : slv_rd[idx];
            e.stalls = 2 + dly; e.req_cycles = dly + 1;
         end
      end else begin
         e.err = 1'b1; e.rdata = 32'h0; e.stalls = 1; e.req_cycles = 0;
      end
      sb_q.push_back(e);

      ready_dly = dly;
      data_w_en = we; data_r_en = re; data_addr = addr; data_sel = sel; data_out = wd;
      #1;
      stalls = 0; reqc = 0; bad = 0; guard = 0;
      while (stall && guard < 64) begin
         stalls++;
         if (s_req != '0) begin
            reqc++;
            if (s_req !== exp_req || s_we !== is_wr || s_sel !== sel ||
                s_addr !== addr || s_wdata !== wd) bad++;
         end
         @(negedge clk);
         guard++;
      end
      e = sb_q.pop_front();
      chk({name, "_done"}, 64'(stall), 64'(0));
      chk({name, "_stalls"}, 64'(stalls), 64'(e.stalls));
      chk({name, "_reqcyc"}, 64'(reqc), 64'(e.req_cycles));
      chk({name, "_latched"}, 64'(bad), 64'(0));
      chk({name, "_err"}, 64'(bus_err), 64'(e.err));
      chk({name, "_din"}, 64'(data_in), 64'(e.rdata));
      last_din = e.rdata;
      data_w_en = 1'b0; data_r_en = 1'b0;
      @(negedge clk);
      chk({name, "_errpulse"}, 64'(bus_err), 64'(0));
      chk({name, "_hold"}, 64'(data_in), 64'(last_din));
      chk({name, "_idle_stall"}, 64'(stall), 64'(0));
      spur = '0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; last_din = '0;
      rst_n = 1'b0; data_w_en = 1'b0; data_r_en = 1'b0;
      data_sel = '0; data_addr = '0; data_out = '0;
      ready_dly = 0; spur = '0; acc_cyc = 0; s_ready = '0;
      slv_rd[0] = 32'h0000_0000; slv_rd[1] = 32'hDEAD_BEEF; slv_rd[2] = 32'hA5A5_0002;
      repeat (3) @(negedge clk);
      chk("rst_req", 64'(s_req), 64'(0));
      chk("rst_err", 64'(bus_err), 64'(0));
      chk("rst_din", 64'(data_in), 64'(0));
      chk("rst_addr", 64'(s_addr), 64'(0));
      chk("rst_stall", 64'(stall), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      do_acc("rd_s1", 1'b0, 1'b1, 32'h4000_0010, 4'b1111, 32'h0, 0);
      do_acc("wr_s0", 1'b1, 1'b0, 32'h0000_0008, 4'b0011, 32'h1234_5678, 3);
      do_acc("unmap", 1'b0, 1'b1, 32'hC000_0000, 4'b1111, 32'h0, 0);
      do_acc("rd_s2", 1'b0, 1'b1, 32'h8000_0004, 4'b1111, 32'h0, 1);
      do_acc("tmo_s2", 1'b0, 1'b1, 32'h8000_0008, 4'b1111, 32'h0, -1);
      do_acc("rd_s1b", 1'b0, 1'b1, 32'h4000_0020, 4'b1111, 32'h0, 2);
      spur = 3'b100;
      do_acc("wr_both", 1'b1, 1'b1, 32'h0000_0020, 4'b1100, 32'hCAFE_F00D, 2);
      do_acc("rd_s2b", 1'b0, 1'b1, 32'h8000_0000, 4'b1111, 32'h0, 0);

      // reset in the second ACCESS cycle of a slave-1 read that never completes
      ready_dly = -1;
      data_r_en = 1'b1; data_addr = 32'h4000_0000; data_sel = 4'b1111;
      @(negedge clk);
      @(negedge clk);
      chk("mid_req_pre", 64'(s_req), 64'(3'b010));
      rst_n = 1'b0; data_r_en = 1'b0;
      @(negedge clk);
      chk("mid_req", 64'(s_req), 64'(0));
      chk("mid_stall", 64'(stall), 64'(0));
      chk("mid_err", 64'(bus_err), 64'(0));
      chk("mid_din", 64'(data_in), 64'(0));
      rst_n = 1'b1; last_din = '0;
      @(negedge clk);
      slv_rd[1] = 32'h0BAD_CAFE;
      do_acc("rd_post", 1'b0, 1'b1, 32'h4000_0004, 4'b1111, 32'h0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/soc_data_bus.md
Name: soc_data_bus

Overview:
Parametrised data-side bus fabric that sits between the core's data port and NUM_SLAVES memory-mapped slaves (data RAM, peripherals). It decodes the top address bits to pick one slave and registers each access. It runs a request/ready handshake with a timeout, and reports unmapped or timed-out accesses. It stalls the core until each access completes, so slaves may have variable latency. This replaces the fixed single-RAM data hookup at SoC top level.

Parameters:
DATA_WIDTH, 32, data bus width; byte lanes = DATA_WIDTH/8
ADDR_WIDTH, 32, core data address width
IDX_W, 2, number of top address bits used as slave index
NUM_SLAVES, 4, populated slaves, 1..2^IDX_W; higher indices are unmapped
TIMEOUT, 16, maximum cycles in ACCESS waiting for ready, >=2
ERR_RDATA, 0, read data returned on error

Ports:
clk  in  1  clock; all state changes on rising edge
_rst  in  1  synchronous active-low reset
data_w_en  in  1  core write request, level, held while stall=1
data_r_en  in  1  core read request, level, held while stall=1
data_sel  in  DATA_WIDTH/8  byte-lane enables
data_addr  in  ADDR_WIDTH  byte address
data_out  in  DATA_WIDTH  core write data
data_in  out  DATA_WIDTH  read data to core, valid in DONE
stall  out  1  core must hold request and pipeline
bus_err  out  1  one-cycle pulse in DONE on unmapped or timeout
s_req  out  NUM_SLAVES  one-hot request, held in ACCESS
s_we  out  1  write qualifier, common to all slaves
s_sel  out  DATA_WIDTH/8  latched byte enables
s_addr  out  ADDR_WIDTH  latched full address
s_wdata  out  DATA_WIDTH  latched write data
s_rdata  in  NUM_SLAVES*DATA_WIDTH  concatenated slave read data; slave k at [k*DATA_WIDTH +: DATA_WIDTH]
s_ready  in  NUM_SLAVES  per-slave completion, sampled only for the selected slave

Behaviour:
- Reset (_rst=0 at an edge):
  - state=IDLE; s_req=0, s_we=0, s_sel=0, s_addr=0, s_wdata=0.
  - data_in=0, bus_err=0, timeout counter=0.
  - Reset applied mid-ACCESS drops s_req at that edge. No completion is signalled.
- Request: req = data_w_en | data_r_en. When both are set, the access is a write and r_en is ignored.
- Decode: idx = data_addr[ADDR_WIDTH-1 -: IDX_W]. mapped = (idx < NUM_SLAVES).
- stall = (state==IDLE & req) | (state==ACCESS). stall=0 in DONE.
- FSM:
  - IDLE, req & mapped: latch addr/sel/wdata/we/idx. s_req[idx]<=1. cnt<=0. Go to ACCESS.
  - IDLE, req & !mapped: go to DONE with bus_err<=1, data_in<=ERR_RDATA. No s_req is ever asserted.
  - IDLE, no req: stay in IDLE.
  - ACCESS, s_ready[idx]=1: s_req<=0. For a read, data_in<=s_rdata slice idx; for a write, data_in unchanged. Go to DONE, bus_err<=0.
  - ACCESS, s_ready[idx]=0: cnt<=cnt+1. When cnt==TIMEOUT-1, s_req<=0, bus_err<=1, data_in<=ERR_RDATA, go to DONE.
  - ACCESS: ready on non-selected slaves is ignored.
  - DONE: the core consumes the result and advances. bus_err returns to 0. Go to IDLE unconditionally.
  - DONE: the request level seen in DONE is the completed one and is not restarted.
- Latency:
  - Mapped access with ready on the first ACCESS cycle takes 3 cycles, IDLE->ACCESS->DONE, with stall high for 2.
  - Unmapped access takes 2 cycles.
  - Back-to-back accesses are issued from IDLE after DONE.
- s_req is one-hot or zero. It stays stable with s_addr/s_wdata/s_sel/s_we for the whole ACCESS.
- data_in holds its value outside DONE until the next read completion or error.

Test Plan:
- Read slave 1, addr 0x4000_0010, s_ready[1] on first ACCESS cycle, s_rdata slice1=0xDEAD_BEEF -> s_req=4'b0010 for 1 cycle; stall high 2 cycles; DONE with data_in=0xDEAD_BEEF, bus_err=0.
- Write slave 0, addr 0x0000_0008, sel=4'b0011, data 0x1234_5678, ready after 3 wait cycles -> s_we=1, s_sel=0011, s_wdata stable 4 cycles; stall low only in DONE.
- With IDX_W=2 and NUM_SLAVES=3, read addr 0xC000_0000 -> no s_req; DONE next cycle with bus_err=1, data_in=ERR_RDATA; total stall 1 cycle.
- TIMEOUT=16, slave 2 never ready -> s_req[2] high exactly 16 cycles, then DONE with bus_err=1 and data_in=0.
- w_en and r_en both set -> write performed; a spurious s_ready[3] during a slave-0 access is ignored.
- _rst=0 on cycle 2 of ACCESS -> next edge s_req=0, state IDLE, stall=0 with no req, bus_err=0; a fresh read afterwards completes normally.
